// File: rtl/ps2_menu_keys_pkg.sv
// ps2_menu_keys_pkg
//   Shared constants for the PS/2 menu keyboard path. It holds the menu
//   command codes driven into the menu page logic, the set-2 scancodes the
//   decoder recognises, the receiver state type and the scancode-to-command
//   map.
package ps2_menu_keys_pkg;

  // Menu command codes (the values seen on the menu's keyboard_in)
  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_UP    = 3'b001;
  localparam logic [2:0] CMD_DOWN  = 3'b010;
  localparam logic [2:0] CMD_ENTER = 3'b011;
  localparam logic [2:0] CMD_ESC   = 3'b100;
  localparam logic [2:0] CMD_LEFT  = 3'b101;
  localparam logic [2:0] CMD_RIGHT = 3'b110;

  // Set-2 scancodes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;  // extended
  localparam logic [7:0] SC_DOWN  = 8'h72;  // extended
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended
  localparam logic [7:0] SC_RIGHT = 8'h74;  // extended

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // Map a non-prefix byte (with the extended flag) to a menu command.
  // Anything not listed returns CMD_NONE, i.e. "no mapping".
  function automatic logic [2:0] map_scancode(input logic ext, input logic [7:0] code);
    logic [2:0] cmd;
    cmd = CMD_NONE;
    if (ext) begin
      case (code)
        SC_UP:    cmd = CMD_UP;
        SC_DOWN:  cmd = CMD_DOWN;
        SC_LEFT:  cmd = CMD_LEFT;
        SC_RIGHT: cmd = CMD_RIGHT;
        default:  cmd = CMD_NONE;
      endcase
    end else begin
      case (code)
        SC_ENTER: cmd = CMD_ENTER;
        SC_ESC:   cmd = CMD_ESC;
        default:  cmd = CMD_NONE;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/ps2_menu_keys_rx.sv
// ps2_rx
//   PS/2 frame receiver: synchronizes ps2_clk/ps2_data, debounces ps2_clk,
//   shifts in 11-bit frames on filtered falling edges and checks start,
//   odd parity and stop. A partial frame is dropped after TIMEOUT_CYC cycles
//   without a falling edge.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   ps2_clk/ps2_data raw keyboard lines (asynchronous)
//   rx_byte          last received byte, valid while byte_valid is high
//   byte_valid       one-cycle pulse per good frame
//   frame_err        one-cycle pulse per bad or timed-out frame
module ps2_rx
  import ps2_menu_keys_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYC - 1);

  logic          clk_s1_reg, clk_s2_reg;
  logic          dat_s1_reg, dat_s2_reg;
  logic          filt_level_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;

  // Synchronizers and ps2_clk filter. The filtered level only flips after
  // FILTER_LEN consecutive samples that disagree with it; fall_reg marks
  // the cycle in which it flips 1->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_reg     <= 1'b1;
      clk_s2_reg     <= 1'b1;
      dat_s1_reg     <= 1'b1;
      dat_s2_reg     <= 1'b1;
      filt_level_reg <= 1'b1;
      filt_cnt_reg   <= '0;
      fall_reg       <= 1'b0;
    end else begin
      clk_s1_reg <= ps2_clk;
      clk_s2_reg <= clk_s1_reg;
      dat_s1_reg <= ps2_data;
      dat_s2_reg <= dat_s1_reg;
      fall_reg   <= 1'b0;
      if (clk_s2_reg == filt_level_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_MAX) begin
        filt_level_reg <= clk_s2_reg;
        filt_cnt_reg   <= '0;
        fall_reg       <= ~clk_s2_reg;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  rx_state_t     state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_ok_reg, par_ok_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          byte_valid_reg, byte_valid_next;
  logic          frame_err_reg, frame_err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RX_IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_ok_reg     <= 1'b0;
      tcnt_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_ok_reg     <= par_ok_next;
      tcnt_reg       <= tcnt_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    par_ok_next     = par_ok_reg;
    tcnt_next       = '0;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    // Idle-time counter only runs mid-frame and restarts on every edge
    if (state_reg != RX_IDLE && !fall_reg) begin
      tcnt_next = tcnt_reg + 1'b1;
    end

    case (state_reg)
      RX_IDLE: begin
        if (fall_reg) begin
          if (!dat_s2_reg) begin
            state_next   = RX_DATA;
            bit_cnt_next = '0;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (fall_reg) begin
          shift_next   = {dat_s2_reg, shift_reg[7:1]};  // LSB first
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (fall_reg) begin
          par_ok_next = ^{dat_s2_reg, shift_reg};  // odd parity over 9 bits
          state_next  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall_reg) begin
          if (dat_s2_reg && par_ok_reg) begin
            byte_valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase

    if (state_reg != RX_IDLE && !fall_reg && tcnt_reg == TOUT_MAX) begin
      state_next     = RX_IDLE;
      tcnt_next      = '0;
      frame_err_next = 1'b1;
    end
  end

  // shift_reg is not touched in STOP, so it still holds the byte while
  // byte_valid is high.
  assign rx_byte    = shift_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_menu_keys.sv
// ps2_menu_keys
//   Turns PS/2 set-2 key traffic into a held 3-bit menu command.
// Ports:
//   clk, rst          system pixel clock, asynchronous active-high reset
//   ps2_clk, ps2_data raw keyboard lines
//   keyboard_out      held menu command (CMD_* codes)
//   key_strobe        one-cycle pulse when keyboard_out takes a new non-zero code
//   frame_err         one-cycle pulse on any receive error or timeout
module ps2_menu_keys
  import ps2_menu_keys_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] keyboard_out,
  output logic       key_strobe,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  logic       ext_reg, ext_next;
  logic       brk_reg, brk_next;
  logic [2:0] key_reg, key_next;
  logic       strobe_reg, strobe_next;
  logic [2:0] cmd;

  assign cmd = map_scancode(ext_reg, rx_byte);

  always_comb begin
    ext_next    = ext_reg;
    brk_next    = brk_reg;
    key_next    = key_reg;
    strobe_next = 1'b0;

    if (rx_err) begin
      // A lost frame may have been part of a prefix sequence
      ext_next = 1'b0;
      brk_next = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_next = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_next = 1'b1;
      end else begin
        ext_next = 1'b0;
        brk_next = 1'b0;
        if (cmd != CMD_NONE) begin
          if (!brk_reg) begin
            // Typematic repeat of the held key is a no-op
            if (cmd != key_reg) begin
              key_next    = cmd;
              strobe_next = 1'b1;
            end
          end else if (cmd == key_reg) begin
            // Releasing a key that was overridden must not drop the newer one
            key_next = CMD_NONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_reg    <= 1'b0;
      brk_reg    <= 1'b0;
      key_reg    <= CMD_NONE;
      strobe_reg <= 1'b0;
    end else begin
      ext_reg    <= ext_next;
      brk_reg    <= brk_next;
      key_reg    <= key_next;
      strobe_reg <= strobe_next;
    end
  end

  assign keyboard_out = key_reg;
  assign key_strobe   = strobe_reg;
  assign frame_err    = rx_err;

endmodule

// File: doc/ps2_menu_keys.md
PS2_MENU_KEYS -- requirements
Module: ps2_menu_keys

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive equal clk samples required to accept a new ps2_clk level.
REQ-002 Parameter TIMEOUT_CYC, default 40000, idle clk cycles after which a partial frame is discarded (1 ms at 40 MHz).
REQ-003 Port clk  input  1  system pixel clock; the only clock; all state on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 Port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 Port keyboard_out  output  3  held menu command code, the value driven into the menu's keyboard_in.
REQ-008 Port key_strobe  output  1  one-cycle pulse when keyboard_out changes to a non-zero code.
REQ-009 Port frame_err  output  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

Function
REQ-010 Inputs ps2_clk and ps2_data shall each pass through a 2-flop synchronizer before any use.
REQ-011 The synchronized ps2_clk shall change its filtered level only after FILTER_LEN consecutive equal samples; a falling edge is a 1->0 change of the filtered level.
REQ-012 Receiver FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: a falling edge with data=0 -> DATA with bit count 0; a falling edge with data=1 -> frame_err, stay IDLE.
- DATA: sample data LSB first on each falling edge; after the 8th bit -> PARITY.
- PARITY: sample; odd parity over 8 data bits plus parity is required.
- STOP: sample; data=1 and parity ok -> byte_valid one cycle; otherwise frame_err; in both cases -> IDLE.
REQ-013 In any state other than IDLE, TIMEOUT_CYC clk cycles without a falling edge shall pulse frame_err and return to IDLE; the counter restarts on each falling edge.
REQ-014 Decoder flags: ext (set by byte E0), brk (set by byte F0); both clear after the next non-prefix byte is consumed; E0 followed by F0 sets both.
REQ-015 Code map (set 2), non-prefix byte with ext as listed: E0 75 -> 3'b001 UP; E0 72 -> 3'b010 DOWN; 5A (ext=0) -> 3'b011 ENTER; 76 (ext=0) -> 3'b100 ESC; E0 6B -> 3'b101 LEFT; E0 74 -> 3'b110 RIGHT; all other bytes -> no mapping.
REQ-016 A mapped make (brk=0) shall set keyboard_out to its code one clk after byte_valid; key_strobe shall pulse in the same cycle only if the new code differs from the previous keyboard_out value.
REQ-017 Typematic repeats of the held key leave keyboard_out unchanged and produce no key_strobe.
REQ-018 A mapped break shall clear keyboard_out to 3'b000 only if it matches the currently held code; a break of any other key leaves keyboard_out unchanged.
REQ-019 A make of a different mapped key while one is held replaces the code (last key wins) and pulses key_strobe.
REQ-020 Unmapped bytes and errored frames shall not alter keyboard_out; a frame error shall clear ext and brk.
REQ-021 Latency from the stop-bit falling edge (filtered) to keyboard_out update: 2 clk cycles.

Reset
REQ-022 While rst=1: keyboard_out=3'b000, key_strobe=0, frame_err=0; FSM in IDLE; ext, brk, counters and filters cleared; synchronizer and filter flops set to 1 (idle bus).
REQ-023 Reset asserted mid-frame shall abandon the frame; the first frame accepted after release starts at a fresh start bit.

Structure
REQ-024 The menu command codes (NONE, UP, DOWN, ENTER, ESC, LEFT, RIGHT) and the scancode constants shall be localparams in a shared include file, also used by the menu page logic.
REQ-025 Sub-module ps2_rx shall hold the synchronizer, filter, frame FSM and timeout and shall output byte, byte_valid and frame_err; decode logic shall remain in ps2_menu_keys.

Verification
REQ-026 Frames E0, 72 -> keyboard_out=3'b010 and one key_strobe; then E0, F0, 72 -> keyboard_out=3'b000 and no strobe.
REQ-027 Make 5A sent 5 times (typematic) -> keyboard_out=3'b011, exactly one key_strobe.
REQ-028 Frame 5A with the parity bit flipped -> frame_err pulse, keyboard_out stays 3'b000.
REQ-029 Send start bit plus 4 data bits, then hold the bus idle for TIMEOUT_CYC+10 cycles, then a full 76 frame -> one frame_err, then keyboard_out=3'b100.
REQ-030 Hold E0 75 (UP), then press 5A, then release E0 75 -> keyboard_out 001, then 011 with a strobe, stays 011 after the UP break.
REQ-031 Assert rst in the middle of DATA of frame 76, release it, then send E0 6B -> keyboard_out=3'b101, no spurious ESC.
